muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers for the EX stage. It executes mult/multu/div/divu and mthi/mtlo, holding the results in HI/LO. The ALU reads `hi`/`lo` for mfhi/mflo (funct 0x10/0x12), so this block sits directly upstream of the ALU's HI/LO read path. It uses one shared shift/add-subtract datapath that retires one bit per cycle.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared funct codes, FSM state type and decode helpers for the multiply/divide unit.
// Also used by the ALU and decode for the mfhi/mflo codes.
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_RUN  = 2'd2,
    S_FIX  = 2'd3
  } muldiv_state_t;

  function automatic logic fn_is_arith(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic fn_is_div(input logic [5:0] f);
    return (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic fn_is_signed(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The master side issues ops; the slave side is the unit itself.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, funct, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, funct, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: right-shifting shift-add for multiply,
// left-shifting restoring trial-subtract for divide, on the {acc/rem, multiplier/quotient} pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff;

  always_comb begin
    w_sum   = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_m} : '0);
    w_trial = {i_acc, i_q[WIDTH-1]};
    // Remainder stays below the divisor, so a W-bit difference is exact when the trial fits.
    w_diff  = w_trial[WIDTH-1:0] - i_m;
    o_acc   = w_sum[WIDTH:1];
    o_q     = {w_sum[0], i_q[WIDTH-1:1]};
    if (i_is_div) begin
      if (w_trial >= {1'b0, i_m}) begin
        o_acc = w_diff;
        o_q   = {i_q[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = w_trial[WIDTH-1:0];
        o_q   = {i_q[WIDTH-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle mult/div unit with architectural HI/LO; one quotient/product bit per cycle.
// Build option MULDIV_SIGNED_EN: when defined, mult/div (0x18/0x1A) are signed.
//
// state  | meaning
// IDLE   | accepts mult/div (-> PREP), mthi/mtlo write directly
// PREP   | operand magnitudes loaded into the iteration registers
// RUN    | WIDTH iterations of the shared step, counter 0..WIDTH-1
// FIX    | sign correction, HI/LO/div_by_zero written, back to IDLE
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     i_clk,
  input logic     i_rst,
  muldiv_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  muldiv_state_t      r_state;
  muldiv_state_t      w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic               w_accept;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;
  logic               w_fix_dbz;

`ifdef MULDIV_SIGNED_EN
  logic r_is_signed;
  logic w_a_neg;
  logic w_b_neg;

  assign w_a_neg = r_is_signed & r_a[WIDTH-1];
  assign w_b_neg = r_is_signed & r_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -r_a : r_a;
  assign w_b_mag = w_b_neg ? -r_b : r_b;
`else
  assign w_a_mag = r_a;
  assign w_b_mag = r_b;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && fn_is_arith(bus.funct)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_PREP;
        end
      end
      S_PREP:  w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (r_state == S_FIX);
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_m      (r_m),
    .o_acc    (w_acc_nxt),
    .o_q      (w_q_nxt)
  );

  always_comb begin
    w_prod    = {r_acc, r_q};
    w_fix_hi  = r_acc;
    w_fix_lo  = r_q;
    w_fix_dbz = r_dbz;
    if (r_is_div) begin
      w_fix_dbz = (r_b == '0);
      // Divide by zero reports the original dividend, not its magnitude.
      if (w_fix_dbz) begin
        w_fix_hi = r_a;
        w_fix_lo = '1;
      end else begin
`ifdef MULDIV_SIGNED_EN
        w_fix_lo = (w_a_neg ^ w_b_neg) ? -r_q : r_q;
        w_fix_hi = w_a_neg ? -r_acc : r_acc;
`endif
      end
    end else begin
`ifdef MULDIV_SIGNED_EN
      if (w_a_neg ^ w_b_neg) w_prod = -w_prod;
`endif
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      r_is_signed <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_is_div <= fn_is_div(bus.funct);
`ifdef MULDIV_SIGNED_EN
            r_is_signed <= fn_is_signed(bus.funct);
`endif
          end else if (bus.start && (bus.funct == FN_MTHI)) begin
            r_hi <= bus.a;
          end else if (bus.start && (bus.funct == FN_MTLO)) begin
            r_lo <= bus.a;
          end
        end
        S_PREP: begin
          r_cnt <= '0;
          r_acc <= '0;
          r_q   <= w_a_mag;
          r_m   <= w_b_mag;
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_hi  <= w_fix_hi;
          r_lo  <= w_fix_lo;
          r_dbz <= w_fix_dbz;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and random ops against an arithmetic
// reference model, latency/busy checks, mthi/mtlo, ignored starts and mid-op reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W       = 32;
  localparam int LAT     = W + 2;
  localparam int BUSY_N  = W + 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;
  logic         exp_dbz;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic   sgn;
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
`ifdef MULDIV_SIGNED_EN
    sgn = (f == FN_MULT) || (f == FN_DIV);
`else
    sgn = 1'b0;
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (f == FN_MTHI) begin
      exp_hi = a;
    end else if (f == FN_MTLO) begin
      exp_lo = a;
    end else if (f == FN_MULT || f == FN_MULTU) begin
      p = sa * sb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (f == FN_DIV || f == FN_DIVU) begin
      if (b == '0) begin
        exp_lo  = '1;
        exp_hi  = a;
        exp_dbz = 1'b1;
      end else begin
        q = sa / sb;
        r = sa % sb;
        exp_lo  = q[31:0];
        exp_hi  = r[31:0];
        exp_dbz = 1'b0;
      end
    end
  endfunction

  // Issues one op at the current negedge and follows it to done (bounded).
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inject_k,
                        output int done_k, output int busy_cnt, output bit hold_ok,
                        output bit busy_at_done, output logic [W-1:0] hi,
                        output logic [W-1:0] lo, output logic dbz);
    bus.start = 1'b1;
    bus.funct = f;
    bus.a     = a;
    bus.b     = b;
    done_k = -1; busy_cnt = 0; hold_ok = 1'b1; busy_at_done = 1'b0;
    hi = 'x; lo = 'x; dbz = 1'bx;
    for (int k = 0; k < LAT + 20; k++) begin
      @(negedge clk);
      bus.start = (k == inject_k);
      bus.funct = (k == inject_k) ? FN_DIV : FN_MULTU;
      bus.a     = $urandom;
      bus.b     = $urandom;
      if (bus.done) begin
        done_k = k; busy_at_done = bus.busy;
        hi = bus.hi; lo = bus.lo; dbz = bus.div_by_zero;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) hold_ok = 1'b0;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.funct = '0; bus.a = '0; bus.b = '0;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.hi, bus.lo} !== {2*W{1'b0}}) begin
      failures++; $display("FAIL reset_hilo got=%h/%h want=0/0", bus.hi, bus.lo);
    end
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      failures++; $display("FAIL reset_flags busy/done/dbz got=%b%b%b want=000",
                           bus.busy, bus.done, bus.div_by_zero);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [5:0]   fl[7] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_DIVU, FN_MULTU, FN_DIVU};
    logic [W-1:0] al[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'h1234, 32'd3, 32'd10};
    logic [W-1:0] bl[7] = '{32'd2, 32'd2, 32'd2, 32'd7, 32'd0, 32'd3, 32'd5};
    int dk, bc; bit hold, bad; logic [W-1:0] h, l; logic z;
    for (int i = 0; i < 7; i++) begin
      run_op(fl[i], al[i], bl[i], -1, dk, bc, hold, bad, h, l, z);
      ref_op(fl[i], al[i], bl[i]);
      checks++;
      if (h !== exp_hi || l !== exp_lo || z !== exp_dbz) begin
        failures++; $display("FAIL directed%0d hi/lo/dbz got=%h/%h/%b want=%h/%h/%b",
                             i, h, l, z, exp_hi, exp_lo, exp_dbz);
      end
      checks++;
      if (dk !== LAT || bc !== BUSY_N || bad !== 1'b0) begin
        failures++; $display("FAIL directed%0d_timing done_k=%0d busy=%0d busy@done=%b want %0d/%0d/0",
                             i, dk, bc, bad, LAT, BUSY_N);
      end
      checks++;
      if (!hold) begin
        failures++; $display("FAIL directed%0d_hold hi/lo changed during op, want %h/%h held", i, exp_hi, exp_lo);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
        failures++; $display("FAIL directed%0d_pulse done got=%b want=0", i, bus.done);
      end
    end
  endtask

  task automatic test_move();
    bus.start = 1'b1; bus.funct = FN_MTHI; bus.a = 32'hDEADBEEF; bus.b = $urandom;
    ref_op(FN_MTHI, 32'hDEADBEEF, '0);
    @(negedge clk);
    checks++;
    if (bus.hi !== exp_hi || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL mthi hi=%h busy=%b done=%b want %h/0/0", bus.hi, bus.busy, bus.done, exp_hi);
    end
    bus.funct = FN_MTLO; bus.a = 32'h0BADF00D;
    ref_op(FN_MTLO, 32'h0BADF00D, '0);
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.lo !== exp_lo || bus.hi !== exp_hi || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL mtlo hi/lo=%h/%h busy=%b done=%b want %h/%h/0/0",
                           bus.hi, bus.lo, bus.busy, bus.done, exp_hi, exp_lo);
    end
    // mfhi, mflo and an unused code must leave everything alone
    bus.start = 1'b1; bus.funct = FN_MFHI; bus.a = $urandom;
    @(negedge clk);
    bus.funct = FN_MFLO; bus.a = $urandom;
    @(negedge clk);
    bus.funct = 6'h05; bus.a = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.busy !== 1'b0 || bus.div_by_zero !== exp_dbz) begin
      failures++; $display("FAIL unknown_funct hi/lo=%h/%h busy=%b dbz=%b want %h/%h/0/%b",
                           bus.hi, bus.lo, bus.busy, bus.div_by_zero, exp_hi, exp_lo, exp_dbz);
    end
  endtask

  task automatic test_overflow();
    int dk, bc; bit hold, bad; logic [W-1:0] h, l; logic z;
    run_op(FN_DIV, 32'h80000000, 32'hFFFFFFFF, -1, dk, bc, hold, bad, h, l, z);
    ref_op(FN_DIV, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if (h !== exp_hi || l !== exp_lo || z !== exp_dbz || dk !== LAT) begin
      failures++; $display("FAIL div_overflow hi/lo/dbz/done_k got=%h/%h/%b/%0d want %h/%h/%b/%0d",
                           h, l, z, dk, exp_hi, exp_lo, exp_dbz, LAT);
    end
  endtask

  task automatic test_ignore_midrun();
    int dk, bc; bit hold, bad; logic [W-1:0] h, l; logic z; int extra_busy;
    @(negedge clk);
    run_op(FN_MULT, 32'd3, 32'd4, 8, dk, bc, hold, bad, h, l, z);
    ref_op(FN_MULT, 32'd3, 32'd4);
    checks++;
    if (h !== 32'd0 || l !== 32'd12 || h !== exp_hi || l !== exp_lo) begin
      failures++; $display("FAIL midrun_result hi/lo got=%h/%h want 0/c", h, l);
    end
    checks++;
    if (bc !== BUSY_N || dk !== LAT) begin
      failures++; $display("FAIL midrun_busy busy=%0d done_k=%0d want %0d/%0d", bc, dk, BUSY_N, LAT);
    end
    extra_busy = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      if (bus.busy || bus.done) extra_busy++;
    end
    checks++;
    if (extra_busy !== 0 || bus.lo !== exp_lo || bus.hi !== exp_hi) begin
      failures++; $display("FAIL midrun_ignored extra busy/done cycles=%0d lo=%h want 0/%h",
                           extra_busy, bus.lo, exp_lo);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[4] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    int dk, bc; bit hold, bad; logic [W-1:0] h, l, a, b; logic z; logic [5:0] f;
    int sel;
    for (int i = 0; i < 40; i++) begin
      f   = ops[$urandom_range(0, 3)];
      a   = $urandom;
      sel = $urandom_range(0, 7);
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) :
            (sel == 2) ? 32'hFFFFFFFF : 32'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        ref_op((i % 2 == 0) ? FN_MTHI : FN_MTLO, a ^ 32'h5A5A5A5A, '0);
        bus.start = 1'b1; bus.funct = (i % 2 == 0) ? FN_MTHI : FN_MTLO; bus.a = a ^ 32'h5A5A5A5A;
        @(negedge clk);
        bus.start = 1'b0;
      end
      run_op(f, a, b, -1, dk, bc, hold, bad, h, l, z);
      ref_op(f, a, b);
      checks++;
      if (h !== exp_hi || l !== exp_lo || z !== exp_dbz) begin
        failures++; $display("FAIL rand%0d f=%h a=%h b=%h got=%h/%h/%b want=%h/%h/%b",
                             i, f, a, b, h, l, z, exp_hi, exp_lo, exp_dbz);
      end
      if (dk !== LAT || bc !== BUSY_N || !hold) begin
        checks++;
        failures++; $display("FAIL rand%0d_timing done_k=%0d busy=%0d hold=%b want %0d/%0d/1",
                             i, dk, bc, hold, LAT, BUSY_N);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int dk, bc; bit hold, bad; logic [W-1:0] h, l; logic z;
    run_op(FN_DIVU, 32'd1000, 32'd33, -1, dk, bc, hold, bad, h, l, z);
    ref_op(FN_DIVU, 32'd1000, 32'd33);
    // Second op issued in the done cycle of the first.
    run_op(FN_MULTU, 32'h0001_0001, 32'h0001_0001, -1, dk, bc, hold, bad, h, l, z);
    checks++;
    if (!hold || dk !== LAT || bc !== BUSY_N) begin
      failures++; $display("FAIL b2b_timing hold=%b done_k=%0d busy=%0d want 1/%0d/%0d", hold, dk, bc, LAT, BUSY_N);
    end
    ref_op(FN_MULTU, 32'h0001_0001, 32'h0001_0001);
    checks++;
    if (h !== exp_hi || l !== exp_lo) begin
      failures++; $display("FAIL b2b_result hi/lo got=%h/%h want=%h/%h", h, l, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset_midrun();
    int dk, bc; bit hold, bad; logic [W-1:0] h, l; logic z; int stray;
    run_op(FN_DIVU, 32'hCAFE, 32'd0, -1, dk, bc, hold, bad, h, l, z);
    ref_op(FN_DIVU, 32'hCAFE, 32'd0);
    bus.start = 1'b1; bus.funct = FN_DIVU; bus.a = 32'd1000; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.hi !== exp_hi || bus.div_by_zero !== 1'b1) begin
      failures++; $display("FAIL pre_reset busy=%b hi=%h dbz=%b want 1/%h/1", bus.busy, bus.hi, bus.div_by_zero, exp_hi);
    end
    rst = 1'b1;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.hi !== '0 || bus.lo !== '0) begin
      failures++; $display("FAIL midrun_reset busy/done/dbz=%b%b%b hi/lo=%h/%h want 000/0/0",
                           bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
    end
    stray = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.lo !== '0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++; $display("FAIL reset_discard stray cycles=%0d want 0", stray);
    end
    run_op(FN_MULTU, 32'd5, 32'd6, -1, dk, bc, hold, bad, h, l, z);
    ref_op(FN_MULTU, 32'd5, 32'd6);
    checks++;
    if (l !== 32'd30 || h !== exp_hi || l !== exp_lo || dk !== LAT || z !== 1'b0) begin
      failures++; $display("FAIL post_reset_multu hi/lo=%h/%h done_k=%0d dbz=%b want %h/%h/%0d/0",
                           h, l, dk, z, exp_hi, exp_lo, LAT);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_move();
    test_overflow();
    test_ignore_midrun();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
